// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 4-digit seven-segment scan controller with tear-free value update
//
// Scans four nibbles of a 16-bit display value onto one shared segment decoder
// and drives the active-low anodes of a common-anode 4-digit display.
//
// Ports:
//   i_clk       system clock, all state on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_din       value to display: [3:0] rightmost digit 0 .. [15:12] digit 3
//   i_load      single-cycle strobe, captures i_din as the next value
//   i_en_mask   per-digit enable, 0 keeps that anode off
//   i_lzb       leading-zero blanking enable
//   o_digit     nibble of the scanned digit, to the shared decoder
//   o_ssd_ctl   anode enables, active-low, at most one bit low
//   o_scan_idx  index of the scanned digit
//   o_upd_done  one-cycle pulse when a loaded value becomes visible
module ssd_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_din,
  input  logic        i_load,
  input  logic [3:0]  i_en_mask,
  input  logic        i_lzb,
  output logic [3:0]  o_digit,
  output logic [3:0]  o_ssd_ctl,
  output logic [1:0]  o_scan_idx,
  output logic        o_upd_done
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_pend_v;
  logic          r_upd_done;

  logic          w_tick;
  logic          w_fb;
  logic          w_lz_blank;
  logic          w_drive;

  assign w_tick = (r_cnt == CW'(DIV - 1));
  // The displayed value only changes at the end of digit 3, so a frame never mixes two values.
  assign w_fb   = w_tick && (r_idx == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_disp     <= 16'h0000;
      r_pend     <= 16'h0000;
      r_pend_v   <= 1'b0;
      r_upd_done <= 1'b0;
    end else begin
      r_upd_done <= 1'b0;

      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_fb) begin
        // A load on the boundary cycle bypasses the pending register.
        if (i_load) begin
          r_disp     <= i_din;
          r_pend_v   <= 1'b0;
          r_upd_done <= 1'b1;
        end else if (r_pend_v) begin
          r_disp     <= r_pend;
          r_pend_v   <= 1'b0;
          r_upd_done <= 1'b1;
        end
      end else if (i_load) begin
        r_pend   <= i_din;
        r_pend_v <= 1'b1;
      end
    end
  end

  // Digit k is a leading zero when nibbles k..3 of the shown value are all zero; digit 0 always shows.
  always_comb begin
    w_lz_blank = 1'b0;
    case (r_idx)
      2'd1:    w_lz_blank = (r_disp[15:4]  == 12'h000);
      2'd2:    w_lz_blank = (r_disp[15:8]  == 8'h00);
      2'd3:    w_lz_blank = (r_disp[15:12] == 4'h0);
      default: w_lz_blank = 1'b0;
    endcase
  end

  // Anodes stay off for the first BLANK_CYC cycles of each slot to avoid ghosting.
  assign w_drive = i_en_mask[r_idx] && (int'(r_cnt) >= BLANK_CYC) && !(i_lzb && w_lz_blank);

  assign o_digit    = r_disp[4*r_idx +: 4];
  assign o_scan_idx = r_idx;
  assign o_ssd_ctl  = w_drive ? ~(4'b0001 << r_idx) : 4'b1111;
  assign o_upd_done = r_upd_done;

endmodule
